// File: rtl/mem_mesh_router_if.sv
// Valid/ready link bundle for one mesh router: five input channels and five output channels.
// The router takes the slave view; the upstream/downstream fabric (or a bench) takes the master view.
interface mem_mesh_router_if #(
    parameter int FLIT_W = 73
);
    logic [4:0]          in_valid;
    logic [5*FLIT_W-1:0] in_flit;
    logic [4:0]          in_ready;
    logic [4:0]          out_valid;
    logic [5*FLIT_W-1:0] out_flit;
    logic [4:0]          out_ready;

    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_flit
    );

    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_flit
    );
endinterface

// File: rtl/mem_mesh_router.sv
// 5-port wormhole mesh router: per-input FIFOs, XY routing, per-output round-robin arbitration
// with an optional priority class, and output locking from head flit until tail flit.
module mem_mesh_router #(
    parameter int PAYLOAD_W    = 64,
    parameter int COORD_W      = 3,
    parameter int ROUTER_X     = 0,
    parameter int ROUTER_Y     = 0,
    parameter int BUFFER_DEPTH = 4,
    parameter int PRIO_EN      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_mesh_router_if.slave  link,
    output logic [4:0]        out_locked,
    output logic              err_sticky
);
    localparam int FLIT_W = PAYLOAD_W + 3 + 2*COORD_W;
    localparam int PTR_W  = $clog2(BUFFER_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HEAD_B = FLIT_W - 1;
    localparam int TAIL_B = FLIT_W - 2;
    localparam int PRIO_B = FLIT_W - 3;
    localparam int DX_LSB = PAYLOAD_W;
    localparam int DY_LSB = PAYLOAD_W + COORD_W;
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(ROUTER_Y);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(BUFFER_DEPTH);
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_SOUTH = 3'd2;
    localparam logic [2:0] P_EAST  = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} out_state_e;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        if (v >= 4'd5) return 3'(v - 4'd5);
        else           return v[2:0];
    endfunction

    logic [FLIT_W-1:0] r_mem [5][BUFFER_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [5];
    logic [PTR_W-1:0]  r_rd_ptr [5];
    logic [CNT_W-1:0]  r_count [5];
    logic [4:0]        r_in_locked;
    out_state_e        r_state [5];
    logic [2:0]        r_owner [5];
    logic [2:0]        r_rr_ptr [5];
    logic              r_err;

    logic [FLIT_W-1:0] w_front [5];
    logic [2:0]        w_route [5];
    logic [2:0]        w_gnt_idx [5];
    logic [2:0]        w_src [5];
    logic [4:0]        w_cand [5];
    logic [4:0]        w_pcand [5];
    logic [4:0]        w_sel [5];
    logic [4:0]        w_empty, w_push, w_pop, w_orphan;
    logic [4:0]        w_grant, w_valid, w_fire, w_fire_tail;

    // FIFO fronts, XY route of each front flit, orphan detection and input ready
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            w_front[p]        = r_mem[p][r_rd_ptr[p]];
            w_empty[p]        = (r_count[p] == {CNT_W{1'b0}});
            link.in_ready[p]  = (r_count[p] != FULL_CNT);
            w_push[p]         = link.in_valid[p] && (r_count[p] != FULL_CNT);
            // A non-head front on an input without a lock can never be forwarded
            w_orphan[p]       = !w_empty[p] && !w_front[p][HEAD_B] && !r_in_locked[p];
            if (w_front[p][DX_LSB +: COORD_W] > MY_X)      w_route[p] = P_EAST;
            else if (w_front[p][DX_LSB +: COORD_W] < MY_X) w_route[p] = P_WEST;
            else if (w_front[p][DY_LSB +: COORD_W] > MY_Y) w_route[p] = P_SOUTH;
            else if (w_front[p][DY_LSB +: COORD_W] < MY_Y) w_route[p] = P_NORTH;
            else                                           w_route[p] = P_LOCAL;
        end
    end

    // Same-cycle arbitration for idle outputs: priority filter, then round-robin from rr_ptr
    always_comb begin
        for (int o = 0; o < 5; o++) begin
            w_grant[o]   = 1'b0;
            w_gnt_idx[o] = 3'd0;
            for (int p = 0; p < 5; p++) begin
                w_cand[o][p]  = !w_empty[p] && w_front[p][HEAD_B] && (w_route[p] == 3'(o)) &&
                                !r_in_locked[p] && (r_state[o] == ST_IDLE);
                w_pcand[o][p] = w_cand[o][p] && w_front[p][PRIO_B];
            end
            if ((PRIO_EN != 0) && (|w_pcand[o])) w_sel[o] = w_pcand[o];
            else                                 w_sel[o] = w_cand[o];
            // Scan downwards so the candidate closest to rr_ptr is written last and wins
            for (int k = 4; k >= 0; k--) begin
                if (w_sel[o][wrap5(4'(r_rr_ptr[o]) + 4'(k))]) begin
                    w_grant[o]   = 1'b1;
                    w_gnt_idx[o] = wrap5(4'(r_rr_ptr[o]) + 4'(k));
                end else begin
                    w_grant[o]   = w_grant[o];
                end
            end
        end
    end

    // Crossbar: each output forwards its owner's front (or the head being granted) and pops it
    always_comb begin
        link.out_flit = '0;
        w_pop         = w_orphan;
        for (int o = 0; o < 5; o++) begin
            if (r_state[o] == ST_LOCKED) begin
                w_src[o]   = r_owner[o];
                w_valid[o] = !w_empty[r_owner[o]];
            end else begin
                w_src[o]   = w_gnt_idx[o];
                w_valid[o] = w_grant[o];
            end
            w_fire[o]          = w_valid[o] && link.out_ready[o];
            w_fire_tail[o]     = w_fire[o] && w_front[w_src[o]][TAIL_B];
            link.out_valid[o]  = w_valid[o];
            if (w_valid[o]) link.out_flit[o*FLIT_W +: FLIT_W] = w_front[w_src[o]];
            else            link.out_flit[o*FLIT_W +: FLIT_W] = {FLIT_W{1'b0}};
        end
        for (int p = 0; p < 5; p++) begin
            for (int o = 0; o < 5; o++) begin
                w_pop[p] = w_pop[p] | (w_fire[o] && (w_src[o] == 3'(p)));
            end
        end
    end

    // Input FIFO storage and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 5; p++) begin
                r_wr_ptr[p] <= {PTR_W{1'b0}};
                r_rd_ptr[p] <= {PTR_W{1'b0}};
                r_count[p]  <= {CNT_W{1'b0}};
            end
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (w_push[p]) begin
                    r_mem[p][r_wr_ptr[p]] <= link.in_flit[p*FLIT_W +: FLIT_W];
                    r_wr_ptr[p]           <= r_wr_ptr[p] + PTR_W'(1'b1);
                end
                if (w_pop[p]) r_rd_ptr[p] <= r_rd_ptr[p] + PTR_W'(1'b1);
                case ({w_push[p], w_pop[p]})
                    2'b10:   r_count[p] <= r_count[p] + CNT_W'(1'b1);
                    2'b01:   r_count[p] <= r_count[p] - CNT_W'(1'b1);
                    default: r_count[p] <= r_count[p];
                endcase
            end
        end
    end

    // Per-output lock FSM, round-robin pointers and sticky orphan error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_locked <= 5'b00000;
            r_err       <= 1'b0;
            for (int o = 0; o < 5; o++) begin
                r_state[o]  <= ST_IDLE;
                r_owner[o]  <= 3'd0;
                r_rr_ptr[o] <= 3'd0;
            end
        end else begin
            if (|w_orphan) r_err <= 1'b1;
            for (int o = 0; o < 5; o++) begin
                case (r_state[o])
                    ST_IDLE: begin
                        if (w_grant[o]) begin
                            r_rr_ptr[o] <= wrap5(4'(w_gnt_idx[o]) + 4'd1);
                            r_owner[o]  <= w_gnt_idx[o];
                            // A single-flit packet grants and releases in the same cycle
                            if (!w_fire_tail[o]) begin
                                r_state[o]                <= ST_LOCKED;
                                r_in_locked[w_gnt_idx[o]] <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_fire_tail[o]) begin
                            r_state[o]             <= ST_IDLE;
                            r_in_locked[r_owner[o]] <= 1'b0;
                        end
                    end
                    default: r_state[o] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            out_locked[o] = (r_state[o] == ST_LOCKED);
        end
        err_sticky = r_err;
    end
endmodule

// File: tb/tb_mem_mesh_router.sv
// Self-checking bench for mem_mesh_router at node (1,1): expected flits are queued per output port
// when driven and compared in order whenever the router transfers a flit.
module tb_mem_mesh_router;
    localparam int PW = 64;
    localparam int CW = 3;
    localparam int FW = PW + 3 + 2*CW;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] out_locked;
    logic       err_sticky;

    always #5 clk = ~clk;

    mem_mesh_router_if #(.FLIT_W(FW)) link();

    mem_mesh_router #(
        .PAYLOAD_W(PW), .COORD_W(CW), .ROUTER_X(1), .ROUTER_Y(1),
        .BUFFER_DEPTH(4), .PRIO_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link(link),
        .out_locked(out_locked), .err_sticky(err_sticky)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [FW-1:0] exp_q [5][$];
    logic [FW-1:0] stim [5];
    logic [FW-1:0] mon_want;

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic pr,
                                         input logic [2:0] dy, input logic [2:0] dx,
                                         input logic [63:0] pl);
        return {h, t, pr, dy, dx, pl};
    endfunction

    // Reference XY route for a router at (1,1)
    function automatic int route_of(input logic [FW-1:0] f);
        logic [2:0] dx;
        logic [2:0] dy;
        dx = f[PW +: CW];
        dy = f[PW+CW +: CW];
        if (dx > 3'd1) return 3;
        if (dx < 3'd1) return 4;
        if (dy > 3'd1) return 2;
        if (dy < 3'd1) return 1;
        return 0;
    endfunction

    task automatic expect_out(input logic [FW-1:0] f);
        exp_q[route_of(f)].push_back(f);
    endtask

    task automatic apply(input logic [4:0] mask);
        for (int p = 0; p < 5; p++) link.in_flit[p*FW +: FW] = stim[p];
        link.in_valid = mask;
        @(posedge clk);
        #1;
        link.in_valid = 5'b00000;
        link.in_flit  = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() +
                exp_q[4].size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (n >= 60) begin
            n_errors++;
            $display("FAIL %s_drain pending=%0d want=0", tag,
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() +
                     exp_q[3].size() + exp_q[4].size());
        end
    endtask

    // Scoreboard: every transfer must match the oldest expected flit on that output
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (link.out_valid[o] && link.out_ready[o]) begin
                    n_checks++;
                    if (exp_q[o].size() == 0) begin
                        n_errors++;
                        $display("FAIL out%0d_unexpected got=%h want=none", o, link.out_flit[o*FW +: FW]);
                    end else begin
                        mon_want = exp_q[o].pop_front();
                        if (link.out_flit[o*FW +: FW] !== mon_want) begin
                            n_errors++;
                            $display("FAIL out%0d_flit got=%h want=%h", o, link.out_flit[o*FW +: FW], mon_want);
                        end
                    end
                end else if (!link.out_valid[o]) begin
                    n_checks++;
                    if (link.out_flit[o*FW +: FW] !== '0) begin
                        n_errors++;
                        $display("FAIL out%0d_idle_flit got=%h want=0", o, link.out_flit[o*FW +: FW]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n          = 1'b0;
        link.out_ready = 5'h1F;
        for (int p = 0; p < 5; p++) link.in_flit[p*FW +: FW] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 64'(p));
        link.in_valid  = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        link.in_valid = 5'h00;
        link.in_flit  = '0;
        @(negedge clk);
        n_checks++;
        if (link.in_ready !== 5'h1F) begin n_errors++; $display("FAIL rst_in_ready got=%h want=1f", link.in_ready); end
        n_checks++;
        if (link.out_valid !== 5'h00) begin n_errors++; $display("FAIL rst_out_valid got=%h want=00", link.out_valid); end
        n_checks++;
        if (out_locked !== 5'h00) begin n_errors++; $display("FAIL rst_out_locked got=%h want=00", out_locked); end
        n_checks++;
        if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL rst_err got=%b want=0", err_sticky); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (link.out_valid !== 5'h00) begin n_errors++; $display("FAIL rst_nothing_buffered got=%h want=00", link.out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_xy_single();
        stim[4] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 64'hA5A5_0123_4567_89AB);
        expect_out(stim[4]);
        apply(5'b10000);
        @(negedge clk);
        n_checks++;
        if (link.out_valid !== 5'b01000) begin n_errors++; $display("FAIL xy_east_valid got=%b want=01000", link.out_valid); end
        n_checks++;
        if (link.out_flit[3*FW +: FW] !== stim[4]) begin
            n_errors++; $display("FAIL xy_east_flit got=%h want=%h", link.out_flit[3*FW +: FW], stim[4]);
        end
        @(posedge clk);
        #1;
        stim[0] = mk(1'b1, 1'b1, 1'b0, 3'd3, 3'd1, 64'h50);
        stim[3] = mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd1, 64'h31);
        expect_out(stim[0]);
        expect_out(stim[3]);
        apply(5'b01001);
        stim[0] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 64'h1111);
        expect_out(stim[0]);
        apply(5'b00001);
        wait_drain("xy");
    endtask

    task automatic test_wormhole();
        logic [FW-1:0] n_pkt [4];
        n_pkt[0] = mk(1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 64'hC0);
        n_pkt[1] = mk(1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 64'hC1);
        n_pkt[2] = mk(1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 64'hC2);
        n_pkt[3] = mk(1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 64'hC3);
        for (int i = 0; i < 4; i++) expect_out(n_pkt[i]);
        stim[2] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 64'hD0);
        expect_out(stim[2]);
        stim[1] = n_pkt[0];
        apply(5'b00010);
        stim[1] = n_pkt[1];
        apply(5'b00110);
        @(negedge clk);
        n_checks++;
        if (out_locked[0] !== 1'b1) begin n_errors++; $display("FAIL worm_locked got=%b want=1", out_locked[0]); end
        @(posedge clk);
        #1;
        stim[1] = n_pkt[2];
        apply(5'b00010);
        stim[1] = n_pkt[3];
        apply(5'b00010);
        wait_drain("worm");
        n_checks++;
        if (out_locked !== 5'h00) begin n_errors++; $display("FAIL worm_released got=%h want=00", out_locked); end
    endtask

    task automatic test_rr_prio();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 4; p++) begin
                stim[p] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 64'h100 + 64'(r*16 + p));
                expect_out(stim[p]);
            end
            apply(5'b01111);
        end
        wait_drain("rr");
        for (int p = 0; p < 4; p++) stim[p] = mk(1'b1, 1'b1, (p == 3), 3'd1, 3'd0, 64'h200 + 64'(p));
        expect_out(stim[3]);
        for (int p = 0; p < 3; p++) expect_out(stim[p]);
        apply(5'b01111);
        wait_drain("prio");
    endtask

    task automatic test_backpressure();
        bit accepted;
        link.out_ready[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stim[4] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 64'hB000 + 64'(i));
            expect_out(stim[4]);
            @(negedge clk);
            n_checks++;
            if (link.in_ready[4] !== 1'b1) begin n_errors++; $display("FAIL bp_ready_%0d got=%b want=1", i, link.in_ready[4]); end
            apply(5'b10000);
        end
        @(negedge clk);
        n_checks++;
        if (link.in_ready[4] !== 1'b0) begin n_errors++; $display("FAIL bp_full got=%b want=0", link.in_ready[4]); end
        n_checks++;
        if (link.out_valid[3] !== 1'b1) begin n_errors++; $display("FAIL bp_held_valid got=%b want=1", link.out_valid[3]); end
        stim[4] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 64'hB004);
        expect_out(stim[4]);
        link.in_flit[4*FW +: FW] = stim[4];
        link.in_valid[4]         = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (link.in_ready[4] !== 1'b0) begin n_errors++; $display("FAIL bp_still_full got=%b want=0", link.in_ready[4]); end
        link.out_ready[3] = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 10 && !accepted; n++) begin
            @(negedge clk);
            if (link.in_ready[4]) accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        link.in_valid = 5'b00000;
        link.in_flit  = '0;
        n_checks++;
        if (!accepted) begin n_errors++; $display("FAIL bp_fifth_accept got=0 want=1"); end
        wait_drain("bp");
    endtask

    task automatic test_orphan();
        stim[1] = mk(1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 64'hDEAD);
        apply(5'b00010);
        @(negedge clk);
        n_checks++;
        if (link.out_valid !== 5'h00) begin n_errors++; $display("FAIL orphan_no_valid got=%h want=00", link.out_valid); end
        @(negedge clk);
        n_checks++;
        if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL orphan_err got=%b want=1", err_sticky); end
        n_checks++;
        if (link.in_ready !== 5'h1F) begin n_errors++; $display("FAIL orphan_discard got=%h want=1f", link.in_ready); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (err_sticky !== 1'b1) begin n_errors++; $display("FAIL orphan_sticky got=%b want=1", err_sticky); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midpkt();
        stim[1] = mk(1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 64'hE0);
        expect_out(stim[1]);
        apply(5'b00010);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (out_locked !== 5'b00001) begin n_errors++; $display("FAIL mid_locked got=%b want=00001", out_locked); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_locked !== 5'h00) begin n_errors++; $display("FAIL mid_unlock got=%h want=00", out_locked); end
        n_checks++;
        if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL mid_err_clear got=%b want=0", err_sticky); end
        n_checks++;
        if (link.out_valid !== 5'h00) begin n_errors++; $display("FAIL mid_out_valid got=%h want=00", link.out_valid); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        link.in_valid  = 5'b00000;
        link.in_flit   = '0;
        link.out_ready = 5'h1F;
        for (int p = 0; p < 5; p++) stim[p] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_xy_single();
        test_wormhole();
        test_rr_prio();
        test_backpressure();
        test_orphan();
        test_reset_midpkt();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
